// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous block RAM between the
// instruction-fetch requester (IF, read only) and the load/store requester
// (MEM, read or write). Each access runs IDLE -> ACCESS -> (WAIT) -> DONE.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; without it MEM always wins over IF.
module ram_port_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_r_nw,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_r_nw_q, ram_r_nw_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              gnt_mem_q, gnt_mem_d;
  logic              grant_mem;

`ifdef RAM_ARB_RR_EN
  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;
  logic last_grant_q, last_grant_d;
`endif

  // Pick the winner for a grant in IDLE; only meaningful when some req is high.
  always_comb begin
`ifdef RAM_ARB_RR_EN
    grant_mem = mem_req & (~if_req | (last_grant_q == GRANT_IF));
`else
    grant_mem = mem_req;
`endif
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    ram_en_d    = ram_en_q;
    ram_r_nw_d  = ram_r_nw_q;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    gnt_mem_d   = gnt_mem_q;
`ifdef RAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || mem_req) begin
          gnt_mem_d = grant_mem;
          ram_en_d  = 1'b1;
          state_d   = S_ACCESS;
          if (grant_mem) begin
            ram_a_d    = mem_addr;
            ram_r_nw_d = mem_rw;
            ram_d_d    = mem_wdata;
          end else begin
            ram_a_d    = if_addr;
            ram_r_nw_d = 1'b1;
          end
`ifdef RAM_ARB_RR_EN
          last_grant_d = grant_mem ? GRANT_MEM : GRANT_IF;
`endif
        end
      end
      S_ACCESS: begin
        ram_en_d = 1'b0;
        if (ram_r_nw_q) begin
          state_d = S_WAIT;
        end else begin
          state_d     = S_DONE;
          mem_ready_d = gnt_mem_q;
          if_ready_d  = ~gnt_mem_q;
        end
      end
      S_WAIT: begin
        state_d = S_DONE;
        if (gnt_mem_q) begin
          mem_rdata_d = ram_q;
          mem_ready_d = 1'b1;
        end else begin
          if_rdata_d = ram_q;
          if_ready_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ram_en_q    <= 1'b0;
      ram_r_nw_q  <= 1'b1;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      gnt_mem_q   <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_grant_q <= GRANT_IF;
`endif
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_r_nw_q  <= ram_r_nw_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      gnt_mem_q   <= gnt_mem_d;
`ifdef RAM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // The enable is gated by reset so a reset in ACCESS suppresses the RAM write.
  assign ram_en    = ram_en_q & ~rst;
  assign ram_r_nw  = ram_r_nw_q;
  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
